shift_sequencer: RTL

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_seq_pkg.sv | 20 ++
 rtl/shift_step.sv | 26 ++
 rtl/shift_sequencer.sv | 109 ++++++++++
 3 files changed

// File: rtl/shift_seq_pkg.sv
// rtl/shift_seq_pkg.sv - shared constants and types for the shift sequencer
// Purpose: datapath widths, shift op encodings and the sequencer FSM state type.
// Ports:   none (package).
package shift_seq_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_RSV = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - one combinational shift step of the sequencer
// Purpose: shift a value by a small step amount according to the shift op.
// Ports:   value_i  value to shift
//          op_i     shift kind (SLL/SRL/SRA; reserved passes through)
//          amt_i    step amount (1, or 4 in multi-bit builds)
//          value_o  shifted value
module shift_step
    import shift_seq_pkg::*;
(
    input  logic [XLEN-1:0]    value_i,
    input  logic [1:0]         op_i,
    input  logic [SHAMT_W-1:0] amt_i,
    output logic [XLEN-1:0]    value_o
);

    always_comb begin
        value_o = value_i;
        case (op_i)
            OP_SLL:  value_o = value_i << amt_i;
            OP_SRL:  value_o = value_i >> amt_i;
            OP_SRA:  value_o = $unsigned($signed(value_i) >>> amt_i);
            default: value_o = value_i;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle iterative shifter with IDLE/SHIFT/DONE FSM
// Purpose: accepts a shift request and iterates one step per clock until the
//          shift amount is consumed, then pulses done with the result.
// Config:  SHIFT_SEQ_MULTIBIT_EN - when defined, steps shift 4 bits while the
//          remaining count is >= 4, else 1 bit; results are unchanged.
// Ports:   clk        clock, rising edge
//          reset      synchronous active-high reset
//          start      request a shift (sampled in IDLE or DONE only)
//          op         shift kind: SLL=00, SRL=01, SRA=11, 10 reserved
//          operand_a  value to shift, sampled with start
//          shamt      shift amount 0..31, sampled with start
//          busy       high while shifting
//          done       one-cycle result-valid pulse
//          result     shifted value, held until next accepted start
module shift_sequencer
    import shift_seq_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [XLEN-1:0]    operand_a,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [XLEN-1:0]    result
);

    state_t             state_q, state_d;
    logic [XLEN-1:0]    work_q, work_d;
    logic [XLEN-1:0]    result_q, result_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [SHAMT_W-1:0] step_amt;
    logic [SHAMT_W-1:0] cnt_dec;
    logic [XLEN-1:0]    step_val;

`ifdef SHIFT_SEQ_MULTIBIT_EN
    assign step_amt = (cnt_q >= SHAMT_W'(4)) ? SHAMT_W'(4) : SHAMT_W'(1);
`else
    assign step_amt = SHAMT_W'(1);
`endif

    assign cnt_dec = cnt_q - step_amt;

    shift_step u_step (
        .value_i (work_q),
        .op_i    (op_q),
        .amt_i   (step_amt),
        .value_o (step_val)
    );

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    work_d = operand_a;
                    cnt_d  = shamt;
                    op_d   = op;
                    // Zero shifts and the reserved op complete straight away.
                    if ((shamt != '0) && (op != OP_RSV)) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d  = ST_DONE;
                        result_d = operand_a;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                work_d = step_val;
                cnt_d  = cnt_dec;
                // Last step: capture the result on the same edge DONE is entered.
                if (cnt_dec == '0) begin
                    state_d  = ST_DONE;
                    result_d = step_val;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            work_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
        end
    end

    assign busy   = (state_q == ST_SHIFT);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;

endmodule
